// File: rtl/adma_as_atx_split.sv
// Purpose: split one descriptor transfer into paired AXI read/write burst requests, 4 KB safe.
// Latency: tx accept -> first atx_vld 2 cycles; burst handshake -> next atx_vld 2 cycles.
// Backpressure: tx_rdy only in IDLE; burst fields held until atx_rdy; issue stalls at the outstanding limit.
module adma_as_atx_split #(
  parameter int DMA_LENGTH_W = 16,
  parameter int SRC_ADDR_W   = 32,
  parameter int DST_ADDR_W   = 32,
  parameter int MST_ID_W     = 5,
  parameter int ATX_LEN_W    = 8,
  parameter int DATA_W       = 32,
  parameter int ATX_NUM_OSTD = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [SRC_ADDR_W-1:0]                 tx_src_addr,
  input  logic [DST_ADDR_W-1:0]                 tx_dst_addr,
  input  logic [DMA_LENGTH_W-1:0]               tx_len,
  input  logic                                  tx_vld,
  output logic                                  tx_rdy,
  input  logic                                  tx_abort,
  output logic                                  tx_done,
  output logic                                  tx_aborted,
  input  logic [MST_ID_W-1:0]                   atx_id,
  input  logic [1:0]                            atx_src_burst,
  input  logic [1:0]                            atx_dst_burst,
  input  logic [DMA_LENGTH_W-1:0]               atx_wd_per_burst,
  output logic [MST_ID_W-1:0]                   arid,
  output logic [SRC_ADDR_W-1:0]                 araddr,
  output logic [ATX_LEN_W-1:0]                  arlen,
  output logic [1:0]                            arburst,
  output logic [MST_ID_W-1:0]                   awid,
  output logic [DST_ADDR_W-1:0]                 awaddr,
  output logic [ATX_LEN_W-1:0]                  awlen,
  output logic [1:0]                            awburst,
  output logic                                  atx_vld,
  input  logic                                  atx_rdy,
  input  logic                                  atx_done,
  output logic [$clog2(ATX_NUM_OSTD+1)-1:0]     atx_ostd
);

  localparam int WB         = DATA_W / 8;
  localparam int LB         = $clog2(WB);
  localparam int OW         = $clog2(ATX_NUM_OSTD + 1);
  localparam int PAGE_BEATS = 4096 / WB;
  // Beat arithmetic width: holds the length, 2^ATX_LEN_W and a full page of beats.
  localparam int CW0        = (DMA_LENGTH_W > ATX_LEN_W + 1) ? DMA_LENGTH_W : ATX_LEN_W + 1;
  localparam int CW         = (CW0 > 14) ? CW0 : 14;
  localparam logic [CW-1:0] MAX_BEATS  = CW'(64'd1 << ATX_LEN_W);
  localparam logic [1:0]    BURST_INCR = 2'b01;

  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [SRC_ADDR_W-1:0]   src_q, src_d;
  logic [DST_ADDR_W-1:0]   dst_q, dst_d;
  logic [DMA_LENGTH_W-1:0] rem_q, rem_d;
  logic [DMA_LENGTH_W-1:0] wpb_q, wpb_d;
  logic [ATX_LEN_W-1:0]    len_q, len_d;
  logic [MST_ID_W-1:0]     id_q, id_d;
  logic [1:0]              sburst_q, sburst_d;
  logic [1:0]              dburst_q, dburst_d;
  logic [OW-1:0]           ostd_q, ostd_d;
  logic                    aborted_q, aborted_d;
  logic                    tx_done_q, tx_done_d;
  logic                    tx_aborted_q, tx_aborted_d;

  logic [CW-1:0]           wpb_eff, src_page, dst_page, calc_beats, iss_beats;
  logic [DMA_LENGTH_W-1:0] rem_after;
  logic                    issue_hs, retire;

  assign tx_rdy     = (state_q == IDLE);
  // Issue gating depends only on state and outstanding count, never on atx_rdy.
  assign atx_vld    = (state_q == ISSUE) && (ostd_q < OW'(ATX_NUM_OSTD));
  assign issue_hs   = atx_vld && atx_rdy;
  assign retire     = atx_done && (ostd_q != '0);

  assign araddr     = src_q;
  assign awaddr     = dst_q;
  assign arlen      = len_q;
  assign awlen      = len_q;
  assign arburst    = sburst_q;
  assign awburst    = dburst_q;
  assign arid       = id_q;
  assign awid       = id_q;
  assign atx_ostd   = ostd_q;
  assign tx_done    = tx_done_q;
  assign tx_aborted = tx_aborted_q;

  // Burst size: smallest of remaining, CSR burst size, AXI length cap and the distance to each 4 KB page end.
  always_comb begin
    wpb_eff    = (wpb_q == '0) ? CW'(1) : CW'(wpb_q);
    src_page   = CW'(PAGE_BEATS) - CW'(src_q[11:LB]);
    dst_page   = CW'(PAGE_BEATS) - CW'(dst_q[11:LB]);
    calc_beats = CW'(rem_q);
    if (wpb_eff < calc_beats) calc_beats = wpb_eff;
    if (MAX_BEATS < calc_beats) calc_beats = MAX_BEATS;
    if ((sburst_q == BURST_INCR) && (src_page < calc_beats)) calc_beats = src_page;
    if ((dburst_q == BURST_INCR) && (dst_page < calc_beats)) calc_beats = dst_page;
    iss_beats  = CW'(len_q) + CW'(1);
    rem_after  = rem_q - DMA_LENGTH_W'(iss_beats);
  end

  // Transfer sequencing: latch descriptor, size each burst, issue it, then wait for retirement.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    wpb_d        = wpb_q;
    len_d        = len_q;
    id_d         = id_q;
    sburst_d     = sburst_q;
    dburst_d     = dburst_q;
    aborted_d    = aborted_q;
    tx_done_d    = 1'b0;
    tx_aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_vld) begin
          src_d     = tx_src_addr;
          dst_d     = tx_dst_addr;
          rem_d     = tx_len;
          wpb_d     = atx_wd_per_burst;
          id_d      = atx_id;
          sburst_d  = atx_src_burst;
          dburst_d  = atx_dst_burst;
          aborted_d = 1'b0;
          state_d   = (tx_len == '0) ? DRAIN : CALC;
        end
      end
      CALC: begin
        if (tx_abort) begin
          aborted_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          len_d   = ATX_LEN_W'(calc_beats - CW'(1));
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Once a request is presented it stays until accepted; abort only acts while stalled.
        if (atx_vld) begin
          if (atx_rdy) begin
            rem_d = rem_after;
            if (sburst_q == BURST_INCR) src_d = src_q + (SRC_ADDR_W'(iss_beats) << LB);
            if (dburst_q == BURST_INCR) dst_d = dst_q + (DST_ADDR_W'(iss_beats) << LB);
            state_d = (rem_after == '0) ? DRAIN : CALC;
          end
        end else if (tx_abort) begin
          aborted_d = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (ostd_q == '0) begin
          state_d      = IDLE;
          tx_done_d    = 1'b1;
          tx_aborted_d = aborted_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding burst count; a retire pulse with nothing outstanding is dropped.
  always_comb begin
    ostd_d = ostd_q;
    if (issue_hs && !retire)      ostd_d = ostd_q + OW'(1);
    else if (!issue_hs && retire) ostd_d = ostd_q - OW'(1);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      wpb_q        <= '0;
      len_q        <= '0;
      id_q         <= '0;
      sburst_q     <= '0;
      dburst_q     <= '0;
      ostd_q       <= '0;
      aborted_q    <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_aborted_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      wpb_q        <= wpb_d;
      len_q        <= len_d;
      id_q         <= id_d;
      sburst_q     <= sburst_d;
      dburst_q     <= dburst_d;
      ostd_q       <= ostd_d;
      aborted_q    <= aborted_d;
      tx_done_q    <= tx_done_d;
      tx_aborted_q <= tx_aborted_d;
    end
  end

endmodule

// File: tb/tb_adma_as_atx_split.sv
// Bench for adma_as_atx_split: directed scenarios plus randomized transfers checked
// against a burst-list model computed from the splitting rules.
module tb_adma_as_atx_split;

  localparam int NOSTD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tx_src_addr, tx_dst_addr;
  logic [15:0] tx_len;
  logic        tx_vld, tx_rdy, tx_abort, tx_done, tx_aborted;
  logic [4:0]  atx_id;
  logic [1:0]  atx_src_burst, atx_dst_burst;
  logic [15:0] atx_wd_per_burst;
  logic [4:0]  arid, awid;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst;
  logic        atx_vld, atx_rdy, atx_done;
  logic [1:0]  atx_ostd;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;

  typedef logic [93:0] req_t;
  req_t expq[$];

  always #5 clk = ~clk;

  adma_as_atx_split #(.ATX_NUM_OSTD(NOSTD)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_src_addr(tx_src_addr), .tx_dst_addr(tx_dst_addr), .tx_len(tx_len),
    .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_abort(tx_abort),
    .tx_done(tx_done), .tx_aborted(tx_aborted),
    .atx_id(atx_id), .atx_src_burst(atx_src_burst), .atx_dst_burst(atx_dst_burst),
    .atx_wd_per_burst(atx_wd_per_burst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy), .atx_done(atx_done), .atx_ostd(atx_ostd)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t cur_req();
    return {araddr, awaddr, arlen, awlen, arburst, awburst, arid, awid};
  endfunction

  // Expected burst list: each burst is the largest step allowed by every cap.
  function automatic void build_model(input logic [31:0] s_in, input logic [31:0] d_in,
                                      input int len, input int wpb,
                                      input logic [1:0] sb, input logic [1:0] db,
                                      input logic [4:0] id);
    logic [31:0] s, d;
    int rem, b, lim;
    s = s_in; d = d_in; rem = len;
    expq.delete();
    while (rem > 0) begin
      b = rem;
      lim = (wpb == 0) ? 1 : wpb;
      if (lim < b) b = lim;
      if (b > 256) b = 256;
      if (sb == 2'b01) begin lim = (4096 - int'(s[11:0])) / 4; if (lim < b) b = lim; end
      if (db == 2'b01) begin lim = (4096 - int'(d[11:0])) / 4; if (lim < b) b = lim; end
      expq.push_back({s, d, 8'(b - 1), 8'(b - 1), sb, db, id, id});
      if (sb == 2'b01) s = s + 32'(b * 4);
      if (db == 2'b01) d = d + 32'(b * 4);
      rem = rem - b;
    end
  endfunction

  // Full transfer with random backpressure and retirement, scoreboarded against the model.
  task automatic run_xfer(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] len, input logic [15:0] wpb,
                          input logic [1:0] sb, input logic [1:0] db, input logic [4:0] id,
                          input int rdy_pct, input int done_pct,
                          output int first_vld, output int done_cyc, output int nhs);
    int ostd_m, n;
    bit fin, hs, dn, hold;
    req_t held;
    build_model(s, d, int'(len), int'(wpb), sb, db, id);
    ostd_m = 0; first_vld = -1; done_cyc = -1; nhs = 0; fin = 0; hold = 0; held = '0;
    tx_abort = 1'b0;
    chk({tag, " idle tx_rdy"}, tx_rdy, 1);
    chk({tag, " ostd at start"}, atx_ostd, 0);
    tx_src_addr = s; tx_dst_addr = d; tx_len = len; atx_wd_per_burst = wpb;
    atx_src_burst = sb; atx_dst_burst = db; atx_id = id; tx_vld = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    n = 1;
    while (!fin && n < 20000) begin
      if (hold) chk({tag, " held request"}, {atx_vld, cur_req()}, {1'b1, held});
      if (atx_vld && first_vld < 0) first_vld = n;
      if (tx_done) begin
        chk({tag, " tx_aborted"}, tx_aborted, 0);
        chk({tag, " tx_rdy with done"}, tx_rdy, 1);
        chk({tag, " bursts left"}, expq.size(), 0);
        done_cyc = n;
        fin = 1;
      end else begin
        atx_rdy = ($urandom_range(99) < rdy_pct);
        hs = atx_vld && atx_rdy;
        dn = (ostd_m > 0) && ($urandom_range(99) < done_pct);
        atx_done = dn;
        chk({tag, " atx_ostd"}, atx_ostd, ostd_m);
        if (hs) begin
          nhs++;
          chk({tag, " burst expected"}, expq.size() != 0, 1);
          if (expq.size() != 0) chk({tag, " burst fields"}, cur_req(), expq.pop_front());
        end
        hold = atx_vld && !atx_rdy;
        held = cur_req();
        ostd_m = ostd_m + int'(hs) - int'(dn);
        @(negedge clk);
        n++;
      end
    end
    atx_rdy = 1'b0;
    atx_done = 1'b0;
    chk({tag, " completed in budget"}, fin, 1);
  endtask

  task automatic step(input bit rdy, input bit dn, input bit ab);
    atx_rdy = rdy; atx_done = dn; tx_abort = ab;
    if (atx_vld && rdy) hs_cnt++;
    @(negedge clk);
  endtask

  task automatic accept(input logic [31:0] s, input logic [31:0] d,
                        input logic [15:0] len, input logic [15:0] wpb);
    tx_src_addr = s; tx_dst_addr = d; tx_len = len; atx_wd_per_burst = wpb;
    atx_src_burst = 2'b01; atx_dst_burst = 2'b01; atx_id = 5'd9; tx_vld = 1'b1;
    @(negedge clk);
    tx_vld = 1'b0;
    hs_cnt = 0;
  endtask

  initial begin
    int fv, dc, nh;
    logic [31:0] rs, rd;
    logic [15:0] rl, rw;
    logic [1:0]  rsb, rdb;
    tx_src_addr = '0; tx_dst_addr = '0; tx_len = '0; tx_vld = 1'b0; tx_abort = 1'b0;
    atx_id = '0; atx_src_burst = '0; atx_dst_burst = '0; atx_wd_per_burst = '0;
    atx_rdy = 1'b0; atx_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst tx_rdy", tx_rdy, 1);
    chk("rst atx_vld", atx_vld, 0);
    chk("rst tx_done", tx_done, 0);
    chk("rst tx_aborted", tx_aborted, 0);
    chk("rst atx_ostd", atx_ostd, 0);
    chk("rst fields", cur_req(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4 KB split example
    run_xfer("split4k", 32'h0000_0FF0, 32'h0001_0000, 16'd40, 16'd16, 2'b01, 2'b01, 5'd3, 100, 50, fv, dc, nh);
    chk("split4k burst count", nh, 4);
    chk("split4k first vld latency", fv, 2);

    // FIXED source
    run_xfer("fixed", 32'h2000_0000, 32'h3000_0000, 16'd10, 16'd4, 2'b00, 2'b01, 5'd7, 70, 40, fv, dc, nh);
    chk("fixed burst count", nh, 3);

    // wpb = 0 gives single-beat bursts
    run_xfer("wpb0", 32'h40, 32'h80, 16'd3, 16'd0, 2'b01, 2'b01, 5'd1, 100, 100, fv, dc, nh);
    chk("wpb0 burst count", nh, 3);

    // AXI length cap
    run_xfer("cap256", 32'h0, 32'h0, 16'd300, 16'd300, 2'b01, 2'b01, 5'd2, 100, 60, fv, dc, nh);
    chk("cap256 burst count", nh, 2);

    // Zero-length transfer
    run_xfer("len0", 32'h100, 32'h200, 16'd0, 16'd4, 2'b01, 2'b01, 5'd4, 100, 50, fv, dc, nh);
    chk("len0 no vld", fv, -1);
    chk("len0 done latency", dc, 2);

    // Outstanding limit, then abort while stalled at the limit
    accept(32'h4000, 32'h8000, 16'd64, 16'd8);
    repeat (20) step(1, 0, 0);
    chk("ostd limit handshakes", hs_cnt, 2);
    chk("ostd limit count", atx_ostd, 2);
    chk("ostd limit vld low", atx_vld, 0);
    step(0, 1, 0);
    repeat (20) step(1, 0, 0);
    chk("ostd limit one more", hs_cnt, 3);
    chk("ostd limit vld low again", atx_vld, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("stall abort no early done", tx_done, 0);
    step(0, 0, 0);
    chk("stall abort done", tx_done, 1);
    chk("stall abort flag", tx_aborted, 1);
    step(0, 0, 0);
    chk("stall abort done pulse", tx_done, 0);

    // Abort while a request waits on atx_rdy
    accept(32'h100, 32'h200, 16'd32, 16'd8);
    step(0, 0, 0);
    chk("abort vld up", atx_vld, 1);
    step(0, 0, 1);
    chk("abort vld kept", atx_vld, 1);
    step(1, 0, 1);
    repeat (8) step(1, 0, 1);
    chk("abort single handshake", hs_cnt, 1);
    chk("abort no reissue", atx_vld, 0);
    chk("abort waits retire", tx_done, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("abort done", tx_done, 1);
    chk("abort flag", tx_aborted, 1);

    // Handshake and retire in the same cycle
    accept(32'h0, 32'h0, 16'd2, 16'd1);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("simul gap vld", atx_vld, 0);
    chk("simul ostd one", atx_ostd, 1);
    step(1, 0, 0);
    chk("simul next vld latency", atx_vld, 1);
    step(1, 1, 0);
    chk("simul ostd unchanged", atx_ostd, 1);
    chk("simul handshakes", hs_cnt, 2);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("simul done", tx_done, 1);
    chk("simul not aborted", tx_aborted, 0);

    // Asynchronous reset while issuing
    accept(32'h1000, 32'h2000, 16'd16, 16'd4);
    step(0, 0, 0);
    chk("areset pre vld", atx_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset vld", atx_vld, 0);
    chk("areset tx_rdy", tx_rdy, 1);
    chk("areset fields", cur_req(), 0);
    chk("areset ostd", atx_ostd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer("post_reset", 32'h1000, 32'h2000, 16'd16, 16'd4, 2'b01, 2'b01, 5'd5, 100, 50, fv, dc, nh);
    chk("post_reset bursts", nh, 4);

    // Randomized transfers
    for (int i = 0; i < 12; i++) begin
      rs = $urandom & 32'hFFFF_FFFC;
      rd = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(1) == 1) rs[11:8] = 4'hF;
      if ($urandom_range(1) == 1) rd[11:8] = 4'hF;
      rl = 16'($urandom_range(200));
      rw = ($urandom_range(5) == 0) ? 16'd300 : 16'($urandom_range(40));
      rsb = 2'($urandom_range(1));
      rdb = 2'($urandom_range(1));
      run_xfer("random", rs, rd, rl, rw, rsb, rdb, 5'($urandom_range(31)),
               30 + int'($urandom_range(70)), 20 + int'($urandom_range(80)), fv, dc, nh);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
